dram_cmd_timing_gate: RTL

Downstream neighbour of `frontend_scheduler`: takes one scheduled DRAM command per handshake and holds it until per-bank and global DRAM timing constraints are met. It then issues it to the DRAM command bus as a registered one-cycle pulse. It tracks open/closed state and open row per bank, and drops protocol-illegal commands with an error pulse.

---
 rtl/dram_cmd_timing_gate_pkg.sv | 19 +
 rtl/dram_cmd_timing_gate_bank_timer.sv | 62 ++++++
 rtl/dram_cmd_timing_gate.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dram_cmd_timing_gate_pkg.sv
// Shared types and default DRAM timing constants for the command timing gate.
package dram_cmd_timing_gate_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_t;

  localparam int DEF_T_RCD = 4;
  localparam int DEF_T_RP  = 4;
  localparam int DEF_T_RAS = 10;
  localparam int DEF_T_CCD = 2;
  localparam int DEF_T_RFC = 20;

endpackage

// File: rtl/dram_cmd_timing_gate_bank_timer.sv
// Per-bank open/row state and the three bank-local timing counters (tRCD, tRAS, tRP).
module bank_timer
  import dram_cmd_timing_gate_pkg::*;
#(
  parameter int ROW_W = 16,
  parameter int CNT_W = 8,
  parameter int T_RCD = DEF_T_RCD,
  parameter int T_RP  = DEF_T_RP,
  parameter int T_RAS = DEF_T_RAS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             act_issue,
  input  logic             pre_issue,
  input  logic [ROW_W-1:0] act_row,
  output logic             is_open,
  output logic [ROW_W-1:0] open_row,
  output logic             act_ok,
  output logic             rdwr_ok,
  output logic             pre_ok
);

  logic [CNT_W-1:0] rcd_cnt;
  logic [CNT_W-1:0] ras_cnt;
  logic [CNT_W-1:0] rp_cnt;

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  // A load on issue wins over the free-running saturating decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_open  <= 1'b0;
      open_row <= '0;
      rcd_cnt  <= '0;
      ras_cnt  <= '0;
      rp_cnt   <= '0;
    end else begin
      if (act_issue) begin
        is_open  <= 1'b1;
        open_row <= act_row;
        rcd_cnt  <= CNT_W'(T_RCD - 1);
        ras_cnt  <= CNT_W'(T_RAS - 1);
      end else begin
        rcd_cnt <= sat_dec(rcd_cnt);
        ras_cnt <= sat_dec(ras_cnt);
      end
      if (pre_issue) begin
        is_open <= 1'b0;
        rp_cnt  <= CNT_W'(T_RP - 1);
      end else begin
        rp_cnt <= sat_dec(rp_cnt);
      end
    end
  end

  assign act_ok  = (rp_cnt == '0);
  assign rdwr_ok = (rcd_cnt == '0);
  assign pre_ok  = (ras_cnt == '0);

endmodule

// File: rtl/dram_cmd_timing_gate.sv
// Holds one scheduled DRAM command until bank/global timing allows it, then issues it as a
// registered one-cycle pulse; protocol-illegal commands are dropped with a cmd_err pulse.
module dram_cmd_timing_gate
  import dram_cmd_timing_gate_pkg::*;
#(
  parameter int BANK_NUM = 8,
  parameter int BANK_W   = $clog2(BANK_NUM),
  parameter int ROW_W    = 16,
  parameter int COL_W    = 10,
  parameter int CNT_W    = 8,
  parameter int T_RCD    = DEF_T_RCD,
  parameter int T_RP     = DEF_T_RP,
  parameter int T_RAS    = DEF_T_RAS,
  parameter int T_CCD    = DEF_T_CCD,
  parameter int T_RFC    = DEF_T_RFC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sch_valid,
  output logic                sch_ready,
  input  logic [2:0]          sch_cmd,
  input  logic [BANK_W-1:0]   sch_bank,
  input  logic [ROW_W-1:0]    sch_row,
  input  logic [COL_W-1:0]    sch_col,
  output logic                dram_cmd_valid,
  output logic [2:0]          dram_cmd,
  output logic [BANK_W-1:0]   dram_bank,
  output logic [ROW_W-1:0]    dram_row,
  output logic [COL_W-1:0]    dram_col,
  output logic [BANK_NUM-1:0] bank_open,
  output logic                cmd_err
);

  logic              hold_v;
  cmd_t              hold_cmd;
  logic [BANK_W-1:0] hold_bank;
  logic [ROW_W-1:0]  hold_row;
  logic [COL_W-1:0]  hold_col;

  logic [CNT_W-1:0]  ccd_cnt;
  logic [CNT_W-1:0]  rfc_cnt;

  logic [BANK_NUM-1:0] is_open;
  logic [BANK_NUM-1:0] act_ok;
  logic [BANK_NUM-1:0] rdwr_ok;
  logic [BANK_NUM-1:0] pre_ok;
  logic [ROW_W-1:0]    open_row [BANK_NUM];

  logic legal;
  logic timing_ok;
  logic issue_now;
  logic drop_now;
  logic accept;
  logic issue_act;
  logic issue_pre;

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  for (genvar i = 0; i < BANK_NUM; i++) begin : g_bank
    bank_timer #(
      .ROW_W(ROW_W), .CNT_W(CNT_W), .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS)
    ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .act_issue(issue_act && (hold_bank == BANK_W'(i))),
      .pre_issue(issue_pre && (hold_bank == BANK_W'(i))),
      .act_row  (hold_row),
      .is_open  (is_open[i]),
      .open_row (open_row[i]),
      .act_ok   (act_ok[i]),
      .rdwr_ok  (rdwr_ok[i]),
      .pre_ok   (pre_ok[i])
    );
  end

  // Evaluate the held command: protocol legality first, then timing readiness.
  always_comb begin
    legal     = 1'b0;
    timing_ok = 1'b0;
    case (hold_cmd)
      CMD_ACT: begin
        legal     = !is_open[hold_bank];
        timing_ok = act_ok[hold_bank] && (rfc_cnt == '0);
      end
      CMD_RD, CMD_WR: begin
        legal     = is_open[hold_bank] && (open_row[hold_bank] == hold_row);
        timing_ok = rdwr_ok[hold_bank] && (ccd_cnt == '0) && (rfc_cnt == '0);
      end
      CMD_PRE: begin
        legal     = is_open[hold_bank];
        timing_ok = pre_ok[hold_bank] && (rfc_cnt == '0);
      end
      CMD_REF: begin
        legal     = ~|is_open;
        timing_ok = (&act_ok) && (rfc_cnt == '0);
      end
      default: begin
        legal     = 1'b0;
        timing_ok = 1'b0;
      end
    endcase
  end

  assign issue_now = hold_v && legal && timing_ok;
  assign drop_now  = hold_v && !legal;
  assign sch_ready = !hold_v || issue_now || drop_now;
  assign accept    = sch_valid && sch_ready && (sch_cmd != CMD_NOP);
  assign issue_act = issue_now && (hold_cmd == CMD_ACT);
  assign issue_pre = issue_now && (hold_cmd == CMD_PRE);
  assign bank_open = is_open;

  // Stage 1: one-entry holding register, refilled in the same cycle it empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v <= 1'b0;
    end else if (accept) begin
      hold_v <= 1'b1;
    end else if (issue_now || drop_now) begin
      hold_v <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      hold_cmd  <= cmd_t'(sch_cmd);
      hold_bank <= sch_bank;
      hold_row  <= sch_row;
      hold_col  <= sch_col;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccd_cnt <= '0;
      rfc_cnt <= '0;
    end else begin
      ccd_cnt <= (issue_now && (hold_cmd == CMD_RD || hold_cmd == CMD_WR)) ?
                 CNT_W'(T_CCD - 1) : sat_dec(ccd_cnt);
      rfc_cnt <= (issue_now && (hold_cmd == CMD_REF)) ? CNT_W'(T_RFC - 1) : sat_dec(rfc_cnt);
    end
  end

  // Stage 2: registered command bus and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dram_cmd_valid <= 1'b0;
      cmd_err        <= 1'b0;
      dram_cmd       <= CMD_NOP;
      dram_bank      <= '0;
      dram_row       <= '0;
      dram_col       <= '0;
    end else begin
      dram_cmd_valid <= issue_now;
      cmd_err        <= drop_now;
      if (issue_now) begin
        dram_cmd  <= hold_cmd;
        dram_bank <= hold_bank;
        dram_row  <= hold_row;
        dram_col  <= hold_col;
      end
    end
  end

endmodule
